bus_arbiter_4_bit: RTL
======================

BUS_ARBITER_4_BIT -- requirements
Module: bus_arbiter_4_bit

Interface
REQ-001 Parameter: TIMEOUT, default 15, maximum consecutive grant cycles per ownership (legal range 1..15).
REQ-002 Port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: req  input  4  per-master bus request; a master holds its bit high for as long as it wants the bus.
REQ-005 Port: grant  output  4  one-hot or zero bus ownership; bit n drives the enable of master n's 4-bit tri-state buffer.
REQ-006 Port: owner  output  2  index of the current owner; valid only while bus_busy=1.
REQ-007 Port: bus_busy  output  1  high while any grant bit is high.
REQ-008 Port: timeout_flag  output  1  one-cycle pulse when a grant is forcibly revoked.

Function
REQ-009 The block SHALL implement three states: IDLE, GRANT and TURN (turnaround).
REQ-010 In IDLE with req=0, the block SHALL remain in IDLE with grant=0.
REQ-011 In IDLE or TURN with req!=0, the block SHALL pick a winner by round-robin and enter GRANT on the next edge, with grant[winner]=1 and owner=winner.
REQ-012 Round-robin SHALL search from index (last_owner+1) mod 4 upward with wrap-around, so the most recent owner has lowest priority.
REQ-013 In GRANT, grant SHALL stay constant while req[owner]=1 and no timeout occurs; requests from other masters SHALL NOT preempt.
REQ-014 When req[owner] falls in GRANT, the block SHALL enter TURN on the next edge with grant=0.
REQ-015 TURN SHALL last exactly one cycle with grant=0, so no two tri-state buffers are ever enabled in the same or adjacent cycles.
REQ-016 From TURN with req=0, the block SHALL enter IDLE.
REQ-017 Request-to-grant latency SHALL be 1 cycle from IDLE; owner-to-owner handover SHALL be exactly 2 cycles (release edge, then TURN).
REQ-018 grant SHALL never have more than one bit set, in every cycle.
REQ-019 A request pulse that deasserts before arbitration samples it SHALL be ignored; no request is latched.
REQ-020 last_owner SHALL update on every GRANT entry.
REQ-021 owner SHALL hold its last value outside GRANT.
REQ-022 bus_busy SHALL equal the OR of the grant bits.

Reset
REQ-023 While reset=1, the block SHALL asynchronously force state=IDLE, grant=0, owner=0, bus_busy=0, timeout_flag=0, last_owner=3 and hold counter=0.
REQ-024 Assertion in any state, including mid-GRANT, SHALL drop grant within the same cycle without a TURN cycle.
REQ-025 On the first edge after reset deasserts, normal arbitration SHALL resume with master 0 at highest priority.

Configuration
REQ-026 The timeout feature SHALL be controlled by the macro ARB_TIMEOUT_EN.
REQ-027 With ARB_TIMEOUT_EN defined, a 4-bit hold counter SHALL count GRANT cycles.
REQ-028 With ARB_TIMEOUT_EN defined, after TIMEOUT grant cycles with req[owner] still high, the block SHALL enter TURN and pulse timeout_flag for one cycle (the TURN cycle).
REQ-029 With ARB_TIMEOUT_EN defined, a revoked master SHALL become lowest priority.
REQ-030 With ARB_TIMEOUT_EN defined, the counter SHALL clear on every GRANT entry.
REQ-031 With ARB_TIMEOUT_EN undefined, no counter SHALL exist, timeout_flag SHALL be tied to 0, and a grant SHALL be held until req[owner] falls.

Verification
REQ-032 Scenario: reset, then req=4'b0101 -> grant=4'b0001 one cycle later; drop req[0] -> grant=0 for one cycle, then grant=4'b0100.
REQ-033 Scenario: all four requests held with ARB_TIMEOUT_EN defined and TIMEOUT=3 -> grants rotate 0001, 0010, 0100, 1000, 0001; each grant lasts 3 cycles, each is separated by one zero cycle, and timeout_flag pulses each time.
REQ-034 Scenario: same stimulus with ARB_TIMEOUT_EN undefined -> grant=4'b0001 held indefinitely and timeout_flag stays 0.
REQ-035 Scenario: reset asserted mid-grant with grant=4'b0100 -> grant=0 immediately; after release with req=4'b1100 -> grant=4'b0100.
REQ-036 Scenario: a 1-cycle req[3] pulse while master 1 owns the bus -> no grant to master 3; after master 1 releases and TURN passes, return to IDLE.
REQ-037 Assertion: the one-hot-or-zero property on grant and the requirement of a zero cycle between different owners SHALL hold across a 10000-cycle random req run.

Source files
------------

// File: rtl/bus_arbiter_4_bit.sv
// bus_arbiter_4_bit: round-robin arbiter for four masters sharing a 4-bit
// tri-state bus. A grant is held until the owner drops its request. A
// one-cycle turnaround with no grant separates any two owners, so two
// buffers are never enabled in the same or adjacent cycles.
//
// Build option: define ARB_TIMEOUT_EN to add a hold counter that revokes a
// grant after TIMEOUT cycles and pulses timeout_flag in the turnaround cycle.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | bus free, no requests seen at the last edge
// GRANT  | grant[owner] asserted, held while req[owner] stays high
// TURN   | one dead cycle after a release or revocation, grant forced to 0
module bus_arbiter_4_bit #(
   parameter int TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] req,
   output logic [3:0] grant,
   output logic [1:0] owner,
   output logic       bus_busy,
   output logic       timeout_flag
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GRANT = 2'd1,
      S_TURN  = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [1:0] owner_q, owner_d;
   logic [1:0] last_owner_q, last_owner_d;
   logic [1:0] winner;
   logic [1:0] cand;
   logic       req_any;

`ifdef ARB_TIMEOUT_EN
   // The counter starts at 0 on grant entry, so the last allowed cycle is TIMEOUT-1.
   localparam logic [3:0] HOLD_LAST = 4'(TIMEOUT - 1);

   logic [3:0] hold_cnt_q, hold_cnt_d;
   logic       tflag_q, tflag_d;
`endif

   // Reject TIMEOUT values the 4-bit hold counter cannot represent.
   if (TIMEOUT < 1 || TIMEOUT > 15) begin : g_timeout_range
      $error("bus_arbiter_4_bit: TIMEOUT must be within 1..15");
   end

   assign req_any = |req;

   // Round-robin pick: scan from last_owner+1 upward with wrap; the smallest
   // offset with a request wins, so the most recent owner ranks last.
   always_comb begin
      winner = last_owner_q + 2'd1;
      cand   = last_owner_q + 2'd1;
      for (int i = 3; i >= 0; i--) begin
         cand = last_owner_q + 2'd1 + 2'(i);
         if (req[cand]) winner = cand;
      end
   end

   // State and bookkeeping registers, all cleared asynchronously.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         owner_q      <= 2'd0;
         last_owner_q <= 2'd3;
`ifdef ARB_TIMEOUT_EN
         hold_cnt_q   <= 4'd0;
         tflag_q      <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
`ifdef ARB_TIMEOUT_EN
         hold_cnt_q   <= hold_cnt_d;
         tflag_q      <= tflag_d;
`endif
      end
   end

   // Next-state logic: arbitrate from IDLE/TURN, hold or release in GRANT.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
`ifdef ARB_TIMEOUT_EN
      hold_cnt_d   = hold_cnt_q;
      tflag_d      = 1'b0;
`endif
      case (state_q)
         S_IDLE, S_TURN: begin
            if (req_any) begin
               state_d      = S_GRANT;
               owner_d      = winner;
               last_owner_d = winner;
`ifdef ARB_TIMEOUT_EN
               hold_cnt_d   = 4'd0;
`endif
            end else begin
               state_d = S_IDLE;
            end
         end
         S_GRANT: begin
            if (!req[owner_q]) begin
               state_d = S_TURN;
`ifdef ARB_TIMEOUT_EN
            end else if (hold_cnt_q == HOLD_LAST) begin
               state_d = S_TURN;
               tflag_d = 1'b1;
            end else begin
               hold_cnt_d = hold_cnt_q + 4'd1;
`endif
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs decode straight from registers so reset clears grant at once.
   always_comb begin
      grant = 4'b0000;
      if (state_q == S_GRANT) grant[owner_q] = 1'b1;
      owner    = owner_q;
      bus_busy = |grant;
`ifdef ARB_TIMEOUT_EN
      timeout_flag = tflag_q;
`else
      timeout_flag = 1'b0;
`endif
   end

endmodule
